// File: rtl/decode_pkg.sv
// Shared decode definitions for instr_decode_stage: opcode/ALU enums,
// instruction field positions and the opcode-to-control decode function.
package decode_pkg;

  localparam int REG_AW  = 3;

  // Instruction field positions (LSB, width)
  localparam int OP_LSB  = 28;
  localparam int OP_W    = 4;
  localparam int RD_LSB  = 25;
  localparam int RS1_LSB = 22;
  localparam int RS2_LSB = 19;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_MOVI = 4'h5,
    OP_LDIM = 4'h6,
    OP_STR  = 4'h7,
    OP_HALT = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // Control bundle produced for one opcode
  typedef struct packed {
    logic    we3;
    logic    rwe2;
    logic    we_im;
    logic    dm_we;
    alu_op_t alu_op;
    logic    uses_src;  // reads rs1/rs2, so subject to the RAW interlock
    logic    writer;    // writes rd, so marks it pending
    logic    halt;
    logic    illegal;
  } dec_t;

  function automatic dec_t decode_op(input logic [OP_W-1:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d.we3      = 1'b1;
        // ADD..OR are 1..4, so the ALU code is op-1 in two bits
        d.alu_op   = alu_op_t'(op[1:0] - 2'd1);
        d.uses_src = 1'b1;
        d.writer   = 1'b1;
      end
      OP_MOVI: begin
        d.rwe2   = 1'b1;
        d.writer = 1'b1;
      end
      OP_LDIM: begin
        d.we_im  = 1'b1;
        d.writer = 1'b1;
      end
      OP_STR: begin
        d.dm_we    = 1'b1;
        d.uses_src = 1'b1;
      end
      OP_HALT: d.halt = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write mask for the register file. Register 0 is the immediate
// selector and is never tracked, so its bit is hard-wired to 0.
module reg_scoreboard #(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_valid,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1,
  input  logic [AW-1:0] q2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:1] pend_q;
  logic [NREGS-1:0] pending;

  assign pending = {pend_q, 1'b0};

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
    // One pending flag per register; a same-cycle set beats a clear
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pend_q[gi] <= 1'b0;
      end else if (set_valid && (set_addr == AW'(gi))) begin
        pend_q[gi] <= 1'b1;
      end else if (clr_valid && (clr_addr == AW'(gi))) begin
        pend_q[gi] <= 1'b0;
      end
    end
  end

  assign busy1 = pending[q1];
  assign busy2 = pending[q2];

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage in front of the 8x32 register file.
// Optional RAW interlock enabled by defining DECODE_SCOREBOARD_EN; without it
// hazards are left to software NOP scheduling and wb_valid/wb_addr are ignored.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] a1,
  output logic [REG_AW-1:0] a2,
  output logic [REG_AW-1:0] a3,
  output logic              we3,
  output logic              rwe2,
  output logic              we_im,
  output logic              dm_we,
  output logic [1:0]        alu_op,
  output logic [7:0]        i2,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  output logic              halted,
  output logic              illegal
);

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [IMM_W-1:0]  imm;
  dec_t              dec;
  logic              hazard;
  logic              accept;

  assign op  = in_instr[OP_LSB  +: OP_W];
  assign rd  = in_instr[RD_LSB  +: REG_AW];
  assign rs1 = in_instr[RS1_LSB +: REG_AW];
  assign rs2 = in_instr[RS2_LSB +: REG_AW];
  assign imm = in_instr[IMM_LSB +: IMM_W];
  assign dec = decode_op(op);

  // Bits between rs2 and imm8 carry no meaning for this stage
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr[RS2_LSB-1:IMM_LSB+IMM_W];

`ifdef DECODE_SCOREBOARD_EN
  logic busy1;
  logic busy2;

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (REG_AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (accept && dec.writer),
    .set_addr  (rd),
    .clr_valid (wb_valid),
    .clr_addr  (wb_addr),
    .q1        (rs1),
    .q2        (rs2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  // Stall only when the incoming instruction actually reads a pending source
  assign hazard = in_valid && dec.uses_src && (busy1 || busy2);
`else
  localparam int unused_nregs = NREGS;
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr};
  assign hazard    = 1'b0;
`endif

  assign in_ready = rst && !halted && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, retire (drop strobes) when consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      we3       <= 1'b0;
      rwe2      <= 1'b0;
      we_im     <= 1'b0;
      dm_we     <= 1'b0;
      alu_op    <= '0;
      i2        <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a1        <= rs1;
      a2        <= rs2;
      a3        <= rd;
      we3       <= dec.we3;
      rwe2      <= dec.rwe2;
      we_im     <= dec.we_im;
      dm_we     <= dec.dm_we;
      alu_op    <= dec.alu_op;
      i2        <= imm;
      if (dec.halt)    halted  <= 1'b1;
      if (dec.illegal) illegal <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      we3       <= 1'b0;
      rwe2      <= 1'b0;
      we_im     <= 1'b0;
      dm_we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage. Honors DECODE_SCOREBOARD_EN the
// same way the RTL does; the reference model tracks pending registers as a
// plain bit array and derives strobes directly from the opcode table.
module tb_instr_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  a1, a2, a3;
  logic        we3, rwe2, we_im, dm_we;
  logic [1:0]  alu_op;
  logic [7:0]  i2;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic        halted, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.NREGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .we3       (we3),
    .rwe2      (rwe2),
    .we_im     (we_im),
    .dm_we     (dm_we),
    .alu_op    (alu_op),
    .i2        (i2),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .halted    (halted),
    .illegal   (illegal)
  );

  // ---------------- reference model ----------------
  bit       m_ov, m_we3, m_rwe2, m_weim, m_dmwe, m_halt, m_ill;
  bit [2:0] m_a1, m_a2, m_a3;
  bit [1:0] m_alu;
  bit [7:0] m_i2;
  bit       m_pend [8];
  bit       exp_ready, obs_ready;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [7:0] imm);
    return {op, rd, rs1, rs2, 11'h000, imm};
  endfunction

  task automatic model_reset();
    m_ov = 0; m_we3 = 0; m_rwe2 = 0; m_weim = 0; m_dmwe = 0;
    m_halt = 0; m_ill = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0; m_alu = 0; m_i2 = 0;
    for (int r = 0; r < 8; r++) m_pend[r] = 0;
  endtask

  function automatic bit model_ready(input bit v, input logic [31:0] ins, input bit ordy);
    int  op;
    bit  reads, haz;
    op    = int'(ins[31:28]);
    reads = (op >= 1 && op <= 4) || op == 7;
    haz   = SB && v && reads && (m_pend[ins[24:22]] || m_pend[ins[21:19]]);
    return (rst === 1'b1) && !m_halt && !haz && (!m_ov || ordy);
  endfunction

  task automatic model_step(input bit v, input logic [31:0] ins, input bit ordy,
                            input bit wbv, input logic [2:0] wba, input bit rdy);
    int op;
    op = int'(ins[31:28]);
    if (SB && wbv) m_pend[wba] = 0;
    if (v && rdy) begin
      m_ov = 1; m_a1 = ins[24:22]; m_a2 = ins[21:19]; m_a3 = ins[27:25]; m_i2 = ins[7:0];
      m_we3 = 0; m_rwe2 = 0; m_weim = 0; m_dmwe = 0; m_alu = 0;
      if (op >= 1 && op <= 4) begin m_we3 = 1; m_alu = 2'(op - 1); end
      else if (op == 5) m_rwe2 = 1;
      else if (op == 6) m_weim = 1;
      else if (op == 7) m_dmwe = 1;
      else if (op == 15) m_halt = 1;
      else if (op >= 8) m_ill = 1;
      if (SB && op >= 1 && op <= 6 && ins[27:25] != 0) m_pend[ins[27:25]] = 1;
    end else if (ordy) begin
      m_ov = 0; m_we3 = 0; m_rwe2 = 0; m_weim = 0; m_dmwe = 0;
    end
  endtask

  // One clock of stimulus: inputs at negedge, in_ready sampled before the
  // edge, model advanced at the edge, outputs valid at posedge+1 on return.
  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy,
                       input bit wbv, input logic [2:0] wba);
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = ordy; wb_valid = wbv; wb_addr = wba;
    #1;
    exp_ready = model_ready(v, ins, ordy);
    obs_ready = in_ready;
    @(posedge clk);
    model_step(v, ins, ordy, wbv, wba, exp_ready);
    #1;
    $display("txn t=%0t v=%0d instr=%08h ordy=%0d wb=%0d/%0d in_ready=%0d out_valid=%0d",
             $time, v, ins, ordy, wbv, wba, obs_ready, out_valid);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; in_valid = 0; in_instr = 0; out_ready = 0; wb_valid = 0; wb_addr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if ({out_valid, we3, rwe2, we_im, dm_we, halted, illegal} !== 7'b0)
      begin errors++; $display("FAIL reset_flags: got %07b want 0", {out_valid, we3, rwe2, we_im, dm_we, halted, illegal}); end
    checks++; if ({a1, a2, a3, alu_op, i2} !== 19'b0)
      begin errors++; $display("FAIL reset_fields: got %05h want 0", {a1, a2, a3, alu_op, i2}); end
    rst = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    drive(1, mk(4'h1, 3'd1, 3'd2, 3'd3, 8'h00), 1, 0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0b want 1", obs_ready); end
    checks++; if ({out_valid, we3, rwe2, we_im, dm_we} !== 5'b11000)
      begin errors++; $display("FAIL add_strobes: got %05b want 11000", {out_valid, we3, rwe2, we_im, dm_we}); end
    checks++; if ({a3, a1, a2, alu_op} !== {3'd1, 3'd2, 3'd3, 2'b00})
      begin errors++; $display("FAIL add_fields: a3=%0d a1=%0d a2=%0d alu=%0d want 1 2 3 0", a3, a1, a2, alu_op); end
    drive(0, 32'h0, 1, 1, 3'd1);  // retire r1 so later tests start clean
    checks++; if ({out_valid, we3} !== 2'b00 || a3 !== 3'd1)
      begin errors++; $display("FAIL add_drain: out_valid=%0b we3=%0b a3=%0d want 0 0 1", out_valid, we3, a3); end
  endtask

  task automatic test_movi_stall();
    drive(1, mk(4'h5, 3'd4, 3'd0, 3'd0, 8'hA5), 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, mk(4'h0, 3'd0, 3'd0, 3'd0, 8'h00), 0, 0, 0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL movi_stall_ready[%0d]: got %0b want 0", k, obs_ready); end
      checks++; if ({out_valid, rwe2, we3, a3, i2} !== {1'b1, 1'b1, 1'b0, 3'd4, 8'hA5})
        begin errors++; $display("FAIL movi_hold[%0d]: ov=%0b rwe2=%0b a3=%0d i2=%02h want 1 1 4 a5", k, out_valid, rwe2, a3, i2); end
    end
    drive(1, mk(4'h0, 3'd0, 3'd0, 3'd0, 8'h00), 1, 1, 3'd4);
    checks++; if (obs_ready !== 1'b1 || rwe2 !== 1'b0 || out_valid !== 1'b1)
      begin errors++; $display("FAIL movi_release: ready=%0b rwe2=%0b ov=%0b want 1 0 1", obs_ready, rwe2, out_valid); end
  endtask

  task automatic test_scoreboard();
    logic [31:0] add_i;
    add_i = mk(4'h1, 3'd6, 3'd5, 3'd1, 8'h00);
    drive(1, mk(4'h5, 3'd5, 3'd0, 3'd0, 8'h3C), 1, 0, 0);
`ifdef DECODE_SCOREBOARD_EN
    for (int k = 0; k < 3; k++) begin
      drive(1, add_i, 1, 0, 0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL sb_stall[%0d]: got %0b want 0", k, obs_ready); end
    end
    drive(1, add_i, 1, 1, 3'd5);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL sb_clear_cycle: got %0b want 0", obs_ready); end
`endif
    drive(1, add_i, 1, 0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ready: got %0b want 1", obs_ready); end
    checks++; if ({out_valid, we3, a3, a1} !== {1'b1, 1'b1, 3'd6, 3'd5})
      begin errors++; $display("FAIL sb_issue: ov=%0b we3=%0b a3=%0d a1=%0d want 1 1 6 5", out_valid, we3, a3, a1); end
    drive(0, 32'h0, 1, 1, 3'd6);
    drive(0, 32'h0, 1, 1, 3'd5);
  endtask

  task automatic test_r0();
    drive(1, mk(4'h5, 3'd0, 3'd0, 3'd0, 8'h11), 1, 0, 0);
    checks++; if ({obs_ready, rwe2, a3, i2} !== {1'b1, 1'b1, 3'd0, 8'h11})
      begin errors++; $display("FAIL r0_movi: ready=%0b rwe2=%0b a3=%0d i2=%02h want 1 1 0 11", obs_ready, rwe2, a3, i2); end
    drive(1, mk(4'h1, 3'd1, 3'd0, 3'd0, 8'h00), 1, 0, 0);
    checks++; if ({obs_ready, we3, a1, a2} !== {1'b1, 1'b1, 3'd0, 3'd0})
      begin errors++; $display("FAIL r0_add: ready=%0b we3=%0b a1=%0d a2=%0d want 1 1 0 0", obs_ready, we3, a1, a2); end
    drive(0, 32'h0, 1, 1, 3'd1);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    bit v, ordy, wbv;
    logic [2:0] wba;
    for (int n = 0; n < 300; n++) begin
      ins  = mk(4'($urandom_range(0, 14)), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      ins  = ins | ($urandom & 32'h0007_FF00);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      wbv  = ($urandom_range(0, 2) == 0);
      wba  = 3'($urandom);
      drive(v, ins, ordy, wbv, wba);
      checks++; if (obs_ready !== exp_ready)
        begin errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, obs_ready, exp_ready); end
      checks++; if ({out_valid, we3, rwe2, we_im, dm_we, halted, illegal} !== {m_ov, m_we3, m_rwe2, m_weim, m_dmwe, m_halt, m_ill})
        begin errors++; $display("FAIL rnd_flags[%0d]: got %07b want %07b", n,
          {out_valid, we3, rwe2, we_im, dm_we, halted, illegal}, {m_ov, m_we3, m_rwe2, m_weim, m_dmwe, m_halt, m_ill}); end
      checks++; if ({a1, a2, a3, alu_op, i2} !== {m_a1, m_a2, m_a3, m_alu, m_i2})
        begin errors++; $display("FAIL rnd_fields[%0d]: got %05h want %05h", n,
          {a1, a2, a3, alu_op, i2}, {m_a1, m_a2, m_a3, m_alu, m_i2}); end
    end
    for (int r = 1; r < 8; r++) drive(0, 32'h0, 1, 1, 3'(r));
  endtask

  task automatic test_illegal_halt();
    drive(1, mk(4'h9, 3'd2, 3'd0, 3'd0, 8'h00), 1, 0, 0);
    checks++; if ({out_valid, we3, rwe2, we_im, dm_we, illegal} !== 6'b100001)
      begin errors++; $display("FAIL illegal_issue: got %06b want 100001", {out_valid, we3, rwe2, we_im, dm_we, illegal}); end
    drive(1, mk(4'hF, 3'd0, 3'd0, 3'd0, 8'h00), 1, 0, 0);
    checks++; if ({obs_ready, out_valid, we3, rwe2, we_im, dm_we, halted} !== 7'b1100001)
      begin errors++; $display("FAIL halt_issue: got %07b want 1100001", {obs_ready, out_valid, we3, rwe2, we_im, dm_we, halted}); end
    for (int k = 0; k < 10; k++) begin
      drive(1, mk(4'h1, 3'd3, 3'd2, 3'd2, 8'h00), 1, 0, 0);
      checks++; if ({obs_ready, halted, out_valid} !== 3'b010)
        begin errors++; $display("FAIL halt_block[%0d]: ready=%0b halted=%0b ov=%0b want 0 1 0", k, obs_ready, halted, out_valid); end
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); rst = 0; #1; model_reset();
    @(negedge clk); rst = 1;
    drive(1, mk(4'h5, 3'd5, 3'd0, 3'd0, 8'h77), 1, 0, 0);
    drive(1, mk(4'h1, 3'd6, 3'd5, 3'd2, 8'h00), 0, 0, 0);
    drive(1, mk(4'h1, 3'd6, 3'd5, 3'd2, 8'h00), 0, 0, 0);
    @(negedge clk); #2; rst = 0; #1;
    model_reset();
    checks++; if ({in_ready, out_valid, rwe2, we3, halted, illegal} !== 6'b0)
      begin errors++; $display("FAIL midreset_flags: got %06b want 0", {in_ready, out_valid, rwe2, we3, halted, illegal}); end
    checks++; if ({a1, a2, a3, alu_op, i2} !== 19'b0)
      begin errors++; $display("FAIL midreset_fields: got %05h want 0", {a1, a2, a3, alu_op, i2}); end
    @(negedge clk); rst = 1;
    drive(1, mk(4'h1, 3'd6, 3'd5, 3'd2, 8'h00), 1, 0, 0);
    checks++; if ({obs_ready, out_valid, we3, a1, a3} !== {1'b1, 1'b1, 1'b1, 3'd5, 3'd6})
      begin errors++; $display("FAIL midreset_issue: ready=%0b ov=%0b we3=%0b a1=%0d a3=%0d want 1 1 1 5 6",
        obs_ready, out_valid, we3, a1, a3); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_movi_stall();
    test_scoreboard();
    test_r0();
    test_random();
    test_illegal_halt();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
